hs_protocol_monitor: RTL and testbench

Synthesizable, multi-channel valid/ready protocol monitor that runs in silicon or emulation alongside the design.
- Checks NUM_CH independent valid/ready/data/last channels for protocol violations.
- Records per-channel sticky error flags and captures the first error.
- Keeps per-channel saturating transfer counters.
- Sits passively on interfaces (no back-pressure); the fabric's debug CSR block reads its outputs.

---
 rtl/hs_mon_pkg.sv | 31 +++
 rtl/hs_mon_channel.sv | 105 ++++++++++
 rtl/hs_protocol_monitor.sv | 113 +++++++++++
 tb/tb_hs_protocol_monitor.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_mon_pkg.sv
// Shared types for the valid/ready protocol monitor.
// err_type_e : 3-bit error type code, also the bit index inside a channel's flag group
// NUM_ERR    : number of error types (width of one channel's flag group)
// lowest_err : lowest set type code of an error-detect vector
package hs_mon_pkg;

    localparam int unsigned NUM_ERR = 5;

    typedef enum logic [2:0] {
        VALID_DROP    = 3'd0,
        DATA_CHANGE   = 3'd1,
        LAST_CHANGE   = 3'd2,
        STALL_TIMEOUT = 3'd3,
        BURST_OVERRUN = 3'd4
    } err_type_e;

    function automatic err_type_e lowest_err(input logic [NUM_ERR-1:0] v);
        err_type_e t;
        logic      found;
        t     = VALID_DROP;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_ERR; i++) begin
            if (v[i] && !found) begin
                t     = err_type_e'(3'(i));
                found = 1'b1;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/hs_mon_channel.sv
// Per-channel protocol checker: history of the previous cycle, stall and beat
// counters, and a saturating transfer counter.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   valid_i/ready_i handshake of the monitored channel
//   data_i, last_i  payload and last-beat marker
//   enable_i        monitor enable; when low all history is held at 0
//   cnt_clear_i     clear the transfer counter (loads 1 on a concurrent transfer)
//   err_o           per-cycle error-detect vector, bit index = err_type_e
//   xfer_count_o    saturating transfer count
module hs_mon_channel
    import hs_mon_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 100,
    parameter int unsigned MAX_BURST  = 256,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic                  ready_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    input  logic                  enable_i,
    input  logic                  cnt_clear_i,
    output logic [NUM_ERR-1:0]    err_o,
    output logic [CNT_WIDTH-1:0]  xfer_count_o
);

    localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
    localparam int unsigned BEAT_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(TIMEOUT);
    localparam logic [STALL_W-1:0] STALL_ARM = STALL_W'(TIMEOUT - 1);
    localparam logic [BEAT_W-1:0]  BEAT_LIM  = BEAT_W'(MAX_BURST - 1);

    logic                  pend_q,  pend_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  plast_q, plast_d;
    logic [STALL_W-1:0]    stall_q, stall_d;
    logic [BEAT_W-1:0]     beat_q,  beat_d;
    logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;

    logic xfer;
    logic stalled;

    assign xfer    = enable_i && valid_i && ready_i;
    assign stalled = enable_i && valid_i && !ready_i;

    always_comb begin
        err_o   = '0;
        pend_d  = stalled;
        pdata_d = enable_i ? data_i : '0;
        plast_d = enable_i && last_i;
        stall_d = '0;
        beat_d  = beat_q;
        cnt_d   = cnt_q;

        // pend_q is only ever set by an enabled cycle, but enable may drop
        // while it is set, so every detector is gated by the current enable.
        err_o[VALID_DROP]    = enable_i && pend_q && !valid_i;
        err_o[DATA_CHANGE]   = enable_i && pend_q && valid_i && (data_i != pdata_q);
        err_o[LAST_CHANGE]   = enable_i && pend_q && valid_i && (last_i != plast_q);
        err_o[STALL_TIMEOUT] = stalled && (stall_q == STALL_ARM);
        err_o[BURST_OVERRUN] = xfer && !last_i && (beat_q == BEAT_LIM);

        if (stalled) begin
            stall_d = (stall_q == STALL_LIM) ? stall_q : stall_q + 1'b1;
        end

        if (!enable_i) begin
            beat_d = '0;
        end else if (xfer) begin
            // An overrun restarts beat counting so the next burst is judged afresh.
            beat_d = (last_i || beat_q == BEAT_LIM) ? '0 : beat_q + 1'b1;
        end

        if (cnt_clear_i) begin
            cnt_d = CNT_WIDTH'(xfer);
        end else if (xfer && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= 1'b0;
            pdata_q <= '0;
            plast_q <= 1'b0;
            stall_q <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            pdata_q <= pdata_d;
            plast_q <= plast_d;
            stall_q <= stall_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign xfer_count_o = cnt_q;

endmodule

// File: rtl/hs_protocol_monitor.sv
// Passive multi-channel valid/ready protocol monitor.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   ch_valid/ch_ready/ch_last        per-channel handshake and last marker
//   ch_data                          per-channel payload, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ch_enable                        per-channel monitor enable
//   err_clear                        clear sticky flags and first-error capture
//   cnt_clear                        clear all transfer counters
//   err_flags                        sticky flags, channel i at [i*5 +: 5]
//   err_irq                          registered OR of the flags
//   first_err_valid/_ch/_type        first-error capture
//   xfer_count                       per-channel saturating transfer counts
module hs_protocol_monitor
    import hs_mon_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 100,
    parameter int unsigned MAX_BURST  = 256,
    parameter int unsigned CNT_WIDTH  = 32,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH-1:0]            ch_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    input  logic [NUM_CH-1:0]            ch_last,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic                         err_clear,
    input  logic                         cnt_clear,
    output logic [NUM_CH*NUM_ERR-1:0]    err_flags,
    output logic                         err_irq,
    output logic                         first_err_valid,
    output logic [CH_W-1:0]              first_err_ch,
    output logic [2:0]                   first_err_type,
    output logic [NUM_CH*CNT_WIDTH-1:0]  xfer_count
);

    logic [NUM_CH*NUM_ERR-1:0] err_det;
    logic [NUM_CH*NUM_ERR-1:0] flags_q, flags_d;
    logic                      irq_q;
    logic                      fv_q, fv_d;
    logic [CH_W-1:0]           fch_q, fch_d;
    err_type_e                 ftype_q, ftype_d;
    logic                      found;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        hs_mon_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .TIMEOUT    (TIMEOUT),
            .MAX_BURST  (MAX_BURST),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .valid_i      (ch_valid[g]),
            .ready_i      (ch_ready[g]),
            .data_i       (ch_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .last_i       (ch_last[g]),
            .enable_i     (ch_enable[g]),
            .cnt_clear_i  (cnt_clear),
            .err_o        (err_det[g*NUM_ERR +: NUM_ERR]),
            .xfer_count_o (xfer_count[g*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    // Set-dominant: a new error in the clearing cycle survives the clear.
    assign flags_d = (err_clear ? '0 : flags_q) | err_det;

    always_comb begin
        fv_d    = fv_q;
        fch_d   = fch_q;
        ftype_d = ftype_q;
        found   = 1'b0;
        if (!fv_q || err_clear) begin
            fv_d    = 1'b0;
            fch_d   = '0;
            ftype_d = VALID_DROP;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!found && |err_det[i*NUM_ERR +: NUM_ERR]) begin
                    found   = 1'b1;
                    fv_d    = 1'b1;
                    fch_d   = CH_W'(i);
                    ftype_d = lowest_err(err_det[i*NUM_ERR +: NUM_ERR]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            irq_q   <= 1'b0;
            fv_q    <= 1'b0;
            fch_q   <= '0;
            ftype_q <= VALID_DROP;
        end else begin
            flags_q <= flags_d;
            irq_q   <= |flags_d;
            fv_q    <= fv_d;
            fch_q   <= fch_d;
            ftype_q <= ftype_d;
        end
    end

    assign err_flags       = flags_q;
    assign err_irq         = irq_q;
    assign first_err_valid = fv_q;
    assign first_err_ch    = fch_q;
    assign first_err_type  = ftype_q;

endmodule

// File: tb/tb_hs_protocol_monitor.sv
module tb_hs_protocol_monitor;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 32;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    ch_valid;
    logic [NCH-1:0]    ch_ready;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_last;
    logic [NCH-1:0]    ch_enable;
    logic              err_clear;
    logic              cnt_clear;
    logic [NCH*5-1:0]  err_flags;
    logic              err_irq;
    logic              first_err_valid;
    logic [1:0]        first_err_ch;
    logic [2:0]        first_err_type;
    logic [NCH*CW-1:0] xfer_count;

    int checks   = 0;
    int failures = 0;

    hs_protocol_monitor #(
        .NUM_CH     (NCH),
        .DATA_WIDTH (DW),
        .TIMEOUT    (100),
        .MAX_BURST  (256),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ch_valid        (ch_valid),
        .ch_ready        (ch_ready),
        .ch_data         (ch_data),
        .ch_last         (ch_last),
        .ch_enable       (ch_enable),
        .err_clear       (err_clear),
        .cnt_clear       (cnt_clear),
        .err_flags       (err_flags),
        .err_irq         (err_irq),
        .first_err_valid (first_err_valid),
        .first_err_ch    (first_err_ch),
        .first_err_type  (first_err_type),
        .xfer_count      (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int unsigned ch, input logic v, input logic r,
                          input logic [31:0] d, input logic l);
        ch_valid[ch]        = v;
        ch_ready[ch]        = r;
        ch_data[ch*DW +: DW] = d;
        ch_last[ch]         = l;
    endtask

    function automatic logic [31:0] cnt(input int unsigned ch);
        return xfer_count[ch*CW +: CW];
    endfunction

    task automatic clear_errors();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
    endtask

    // n_beats transfers on ch3; only the final one carries last_final.
    task automatic burst3(input int unsigned n_beats, input logic last_final);
        for (int unsigned b = 0; b < n_beats; b++) begin
            set_ch(3, 1'b1, 1'b1, b, (b == n_beats - 1) ? last_final : 1'b0);
            tick();
        end
        set_ch(3, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        ch_valid  = '0;
        ch_ready  = '0;
        ch_data   = '0;
        ch_last   = '0;
        ch_enable = '1;
        err_clear = 1'b0;
        cnt_clear = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_flags", 32'(err_flags), 32'h0);
        check("rst_irq",   32'(err_irq), 32'h0);
        check("rst_fv",    32'(first_err_valid), 32'h0);
        check("rst_fch",   32'(first_err_ch), 32'h0);
        check("rst_ftype", 32'(first_err_type), 32'h0);
        check("rst_cnt0",  cnt(0), 32'h0);
        check("rst_cnt3",  cnt(3), 32'h0);
        rst_n = 1'b1;
        tick();

        // Ch0 VALID_DROP
        set_ch(0, 1'b1, 1'b0, 32'hA5, 1'b0);
        tick();
        check("drop_pre_flags", 32'(err_flags), 32'h0);
        set_ch(0, 1'b0, 1'b0, 32'hA5, 1'b0);
        tick();
        check("drop_flags", 32'(err_flags), 32'h00001);
        check("drop_irq",   32'(err_irq), 32'h1);
        check("drop_fv",    32'(first_err_valid), 32'h1);
        check("drop_fch",   32'(first_err_ch), 32'h0);
        check("drop_ftype", 32'(first_err_type), 32'h0);
        clear_errors();
        check("clr_flags", 32'(err_flags), 32'h0);
        check("clr_irq",   32'(err_irq), 32'h0);
        check("clr_fv",    32'(first_err_valid), 32'h0);

        // Ch1 DATA_CHANGE
        set_ch(1, 1'b1, 1'b0, 32'h10, 1'b0);
        tick();
        set_ch(1, 1'b1, 1'b0, 32'h11, 1'b0);
        tick();
        check("dchg_flags", 32'(err_flags), 32'h00040);
        check("dchg_fch",   32'(first_err_ch), 32'h1);
        check("dchg_ftype", 32'(first_err_type), 32'h1);
        set_ch(1, 1'b1, 1'b1, 32'h11, 1'b0);
        tick();
        set_ch(1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        check("dchg_hold_flags", 32'(err_flags), 32'h00040);
        check("dchg_cnt1", cnt(1), 32'd1);
        clear_errors();

        // Ch2 STALL_TIMEOUT
        set_ch(2, 1'b1, 1'b0, 32'h33, 1'b0);
        repeat (99) tick();
        check("to_99_flags", 32'(err_flags), 32'h0);
        tick();
        check("to_100_flags", 32'(err_flags), 32'h02000);
        check("to_fch",   32'(first_err_ch), 32'h2);
        check("to_ftype", 32'(first_err_type), 32'h3);
        check("to_irq",   32'(err_irq), 32'h1);
        clear_errors();
        repeat (3) tick();
        check("to_once_flags", 32'(err_flags), 32'h0);
        check("to_once_fv",    32'(first_err_valid), 32'h0);
        set_ch(2, 1'b1, 1'b1, 32'h33, 1'b0);
        tick();
        check("to_cnt2", cnt(2), 32'd1);
        set_ch(2, 1'b1, 1'b0, 32'h34, 1'b0);
        repeat (99) tick();
        check("to_restart_flags", 32'(err_flags), 32'h0);
        set_ch(2, 1'b1, 1'b1, 32'h34, 1'b0);
        tick();
        set_ch(2, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        check("to_cnt2b", cnt(2), 32'd2);

        // Ch3 bursts
        burst3(256, 1'b1);
        tick();
        check("burst_ok_flags", 32'(err_flags), 32'h0);
        burst3(256, 1'b0);
        tick();
        check("overrun_flags", 32'(err_flags), 32'h80000);
        check("overrun_fch",   32'(first_err_ch), 32'h3);
        check("overrun_ftype", 32'(first_err_type), 32'h4);
        clear_errors();
        burst3(256, 1'b1);
        tick();
        check("resync_flags", 32'(err_flags), 32'h0);
        check("burst_cnt3", cnt(3), 32'd768);

        // Same-cycle errors on ch2 (type 0) and ch0 (type 1)
        set_ch(2, 1'b1, 1'b0, 32'h0, 1'b0);
        set_ch(0, 1'b1, 1'b0, 32'h1, 1'b0);
        tick();
        set_ch(2, 1'b0, 1'b0, 32'h0, 1'b0);
        set_ch(0, 1'b1, 1'b0, 32'h2, 1'b0);
        tick();
        check("prio_flags", 32'(err_flags), 32'h00402);
        check("prio_fch",   32'(first_err_ch), 32'h0);
        check("prio_ftype", 32'(first_err_type), 32'h1);
        set_ch(0, 1'b1, 1'b1, 32'h2, 1'b0);
        tick();
        set_ch(0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        check("prio_hold_flags", 32'(err_flags), 32'h00402);
        // err_clear coinciding with ch1 VALID_DROP
        set_ch(1, 1'b1, 1'b0, 32'h7, 1'b0);
        tick();
        set_ch(1, 1'b0, 1'b0, 32'h7, 1'b0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("clrerr_flags", 32'(err_flags), 32'h00020);
        check("clrerr_fv",    32'(first_err_valid), 32'h1);
        check("clrerr_fch",   32'(first_err_ch), 32'h1);
        check("clrerr_ftype", 32'(first_err_type), 32'h0);
        clear_errors();

        // cnt_clear, back-to-back transfers, enable gating
        check("cnt0_before", cnt(0), 32'd1);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        check("cntclr_cnt0", cnt(0), 32'd0);
        check("cntclr_cnt3", cnt(3), 32'd0);
        for (int unsigned k = 0; k < 10; k++) begin
            set_ch(0, 1'b1, 1'b1, 32'h100 + k, 1'b0);
            tick();
        end
        set_ch(0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        check("b2b_flags", 32'(err_flags), 32'h0);
        check("b2b_cnt0",  cnt(0), 32'd10);
        set_ch(0, 1'b1, 1'b0, 32'h55, 1'b0);
        tick();
        ch_enable[0] = 1'b0;
        tick();
        set_ch(0, 1'b1, 1'b1, 32'h66, 1'b0);
        tick();
        set_ch(0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        ch_enable[0] = 1'b1;
        tick();
        check("en_flags", 32'(err_flags), 32'h0);
        check("en_cnt0",  cnt(0), 32'd10);
        set_ch(0, 1'b1, 1'b1, 32'h77, 1'b0);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        set_ch(0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("cntclr_xfer_cnt0", cnt(0), 32'd1);
        tick();

        // Reset mid-stall discards history
        set_ch(2, 1'b1, 1'b0, 32'h9, 1'b0);
        repeat (50) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_flags", 32'(err_flags), 32'h0);
        check("midrst_cnt0",  cnt(0), 32'd0);
        check("midrst_fv",    32'(first_err_valid), 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (60) tick();
        check("postrst_flags", 32'(err_flags), 32'h0);
        check("postrst_irq",   32'(err_irq), 32'h0);
        set_ch(2, 1'b1, 1'b1, 32'h9, 1'b0);
        tick();
        set_ch(2, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        check("postrst_cnt2", cnt(2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
